// File: rtl/lfsr_ctrl_if.sv
// Valid/ready word stream carrying LFSR output words from lfsr_ctrl to its consumer.
interface lfsr_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_ctrl.sv
// Sequencer for an external chain of single-bit LFSR nodes: seeds the chain, then
// steps it once per accepted output word and stops after a programmed word count.
//
// state  | meaning
// IDLE   | nodes cleared (ld=en=0); waits for start
// LOAD   | one cycle, nodes load seed_r
// RUN    | nodes enabled, out_valid high; steps on out_ready, otherwise recirculates
// DONE   | one-cycle done pulse, nodes cleared
module lfsr_ctrl #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'('hB8),
   parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] seed_in,
   input  logic [15:0]      num_words,
   lfsr_ctrl_if.master      stream,
   output logic             busy,
   output logic             done,
   output logic             seed_fixed,
   output logic [WIDTH-1:0] node_ld,
   output logic [WIDTH-1:0] node_en,
   output logic [WIDTH-1:0] node_seed,
   output logic [WIDTH-1:0] node_d,
   input  logic [WIDTH-1:0] node_q
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [15:0]      cnt;
   logic [WIDTH-1:0] seed_r;
   logic             ld_all;
   logic             en_all;
   logic             accept;
   logic             fb;
   logic [WIDTH-1:0] nxt;

   assign fb  = ^(node_q & TAPS);
   assign nxt = {node_q[WIDTH-2:0], fb};

   assign node_ld         = {WIDTH{ld_all}};
   assign node_en         = {WIDTH{en_all}};
   assign stream.out_data = node_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= 16'd0;
         seed_r     <= '0;
         seed_fixed <= 1'b0;
      end else if (state == S_IDLE && start) begin
         cnt        <= num_words;
         seed_r     <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
         seed_fixed <= (seed_in == '0);
      end else if (accept) begin
         cnt <= cnt - 16'd1;
      end
   end

   // The nodes clear whenever ld and en are both low, so RUN keeps en high and
   // stalls by feeding node_q straight back.
   always_comb begin
      state_nxt        = state;
      ld_all           = 1'b0;
      en_all           = 1'b0;
      accept           = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;
      stream.out_valid = 1'b0;
      node_seed        = '0;
      node_d           = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (num_words == 16'd0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            ld_all    = 1'b1;
            busy      = 1'b1;
            node_seed = seed_r;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            en_all           = 1'b1;
            busy             = 1'b1;
            stream.out_valid = 1'b1;
            if (stream.out_ready) begin
               node_d = nxt;
               accept = 1'b1;
               if (cnt == 16'd1) begin
                  state_nxt = S_DONE;
               end
            end else begin
               node_d = node_q;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Bench for lfsr_ctrl: behavioural node array, arithmetic LFSR reference model,
// one task per scenario.
module tb_lfsr_ctrl;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        start     = 1'b0;
   logic [7:0]  seed_in   = 8'h00;
   logic [15:0] num_words = 16'd0;
   logic        busy;
   logic        done;
   logic        seed_fixed;
   logic [7:0]  node_ld;
   logic [7:0]  node_en;
   logic [7:0]  node_seed;
   logic [7:0]  node_d;
   logic [7:0]  node_q    = 8'h00;

   int checks = 0;
   int errors = 0;
   logic [7:0] cap [0:255];

   lfsr_ctrl_if #(.WIDTH(8)) sif ();

   lfsr_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .seed_in    (seed_in),
      .num_words  (num_words),
      .stream     (sif),
      .busy       (busy),
      .done       (done),
      .seed_fixed (seed_fixed),
      .node_ld    (node_ld),
      .node_en    (node_en),
      .node_seed  (node_seed),
      .node_d     (node_d),
      .node_q     (node_q)
   );

   always #5 clk = ~clk;

   // single-bit nodes: load, enable, otherwise clear
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (node_ld[i])      node_q[i] <= node_seed[i];
         else if (node_en[i]) node_q[i] <= node_d[i];
         else                 node_q[i] <= 1'b0;
      end
   end

   function automatic logic [7:0] ref_next(input logic [7:0] q);
      int hits;
      int v;
      hits = $countones(q & 8'hB8);
      v    = (int'(q) * 2) % 256 + hits % 2;
      return 8'(v);
   endfunction

   // Caller must be at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
   task automatic run_words(input logic [7:0] seed, input int n, input int mode);
      logic [7:0] eseed;
      logic [7:0] word;
      logic [7:0] nxt_w;
      int k;
      int cyc;
      int budget;
      bit rdy;
      eseed = (seed == 8'h00) ? 8'h01 : seed;
      start = 1'b1; seed_in = seed; num_words = 16'(n); sif.out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; seed_in = 8'($urandom); num_words = 16'($urandom);
      if (n == 0) begin
         checks++;
         if ({done, busy, sif.out_valid} !== 3'b100) begin
            errors++; $display("FAIL zero_words_done: got %b expected 100", {done, busy, sif.out_valid});
         end
         checks++;
         if (seed_fixed !== (seed == 8'h00)) begin
            errors++; $display("FAIL zero_words_seed_fixed: got %b expected %b", seed_fixed, (seed == 8'h00));
         end
         @(negedge clk);
         checks++;
         if ({done, busy, sif.out_valid} !== 3'b000) begin
            errors++; $display("FAIL zero_words_idle: got %b expected 000", {done, busy, sif.out_valid});
         end
         return;
      end
      checks++;
      if ({busy, sif.out_valid, done} !== 3'b100) begin
         errors++; $display("FAIL load_flags: got %b expected 100", {busy, sif.out_valid, done});
      end
      checks++;
      if (node_ld !== 8'hFF || node_seed !== eseed) begin
         errors++; $display("FAIL load_seed: got ld=%h seed=%h expected ld=ff seed=%h", node_ld, node_seed, eseed);
      end
      checks++;
      if (seed_fixed !== (seed == 8'h00)) begin
         errors++; $display("FAIL seed_fixed: got %b expected %b", seed_fixed, (seed == 8'h00));
      end
      word = eseed; k = 0; cyc = 0; budget = 8 * n + 20;
      while (k < n && cyc < budget) begin
         @(negedge clk);
         checks++;
         if ({sif.out_valid, busy, done} !== 3'b110 || node_en !== 8'hFF) begin
            errors++; $display("FAIL run_flags: got vbd=%b en=%h expected vbd=110 en=ff", {sif.out_valid, busy, done}, node_en);
         end
         checks++;
         if (sif.out_data !== word) begin
            errors++; $display("FAIL run_data word %0d: got %h expected %h", k, sif.out_data, word);
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         sif.out_ready = rdy;
         #1;
         nxt_w = ref_next(word);
         checks++;
         if (node_d !== (rdy ? nxt_w : word)) begin
            errors++; $display("FAIL node_d ready=%b: got %h expected %h", rdy, node_d, (rdy ? nxt_w : word));
         end
         if (rdy) begin
            if (k < 256) cap[k] = sif.out_data;
            k++;
            word = nxt_w;
         end
         cyc++;
      end
      checks++;
      if (k < n) begin
         errors++; $display("FAIL run_timeout: got %0d words expected %0d", k, n);
      end
      @(negedge clk);
      sif.out_ready = 1'b0;
      checks++;
      if ({done, busy, sif.out_valid} !== 3'b100 || node_en !== 8'h00 || node_ld !== 8'h00) begin
         errors++; $display("FAIL done_pulse: got dbv=%b en=%h ld=%h expected dbv=100 en=00 ld=00",
                            {done, busy, sif.out_valid}, node_en, node_ld);
      end
      @(negedge clk);
      checks++;
      if ({done, busy, sif.out_valid} !== 3'b000 || sif.out_data !== 8'h00) begin
         errors++; $display("FAIL post_idle: got dbv=%b data=%h expected dbv=000 data=00",
                            {done, busy, sif.out_valid}, sif.out_data);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; sif.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, sif.out_valid, seed_fixed} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, sif.out_valid, seed_fixed});
      end
      checks++;
      if ({node_ld, node_en, node_seed, node_d} !== 32'h0) begin
         errors++; $display("FAIL reset_nodes: got %h expected 00000000", {node_ld, node_en, node_seed, node_d});
      end
      checks++;
      if (sif.out_data !== 8'h00) begin
         errors++; $display("FAIL reset_data: got %h expected 00", sif.out_data);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, sif.out_valid} !== 3'b000) begin
         errors++; $display("FAIL idle_after_reset: got %b expected 000", {busy, done, sif.out_valid});
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp_w [0:4];
      exp_w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      run_words(8'h01, 5, 0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cap[i] !== exp_w[i]) begin
            errors++; $display("FAIL basic_word %0d: got %h expected %h", i, cap[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [7:0] exp_w [0:4];
      exp_w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      run_words(8'h01, 5, 1);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cap[i] !== exp_w[i]) begin
            errors++; $display("FAIL stall_word %0d: got %h expected %h", i, cap[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_zero_seed();
      run_words(8'h00, 3, 0);
      checks++;
      if (seed_fixed !== 1'b1 || cap[0] !== 8'h01 || cap[2] !== 8'h04) begin
         errors++; $display("FAIL zero_seed: got fixed=%b w0=%h w2=%h expected fixed=1 w0=01 w2=04",
                            seed_fixed, cap[0], cap[2]);
      end
      run_words(8'h11, 3, 0);
      checks++;
      if (seed_fixed !== 1'b0 || cap[0] !== 8'h11 || cap[1] !== 8'h23) begin
         errors++; $display("FAIL reseed: got fixed=%b w0=%h w1=%h expected fixed=0 w0=11 w1=23",
                            seed_fixed, cap[0], cap[1]);
      end
   endtask

   task automatic test_wrap();
      bit seen [0:255];
      int dups;
      run_words(8'h01, 256, 0);
      checks++;
      if (cap[255] !== 8'h01) begin
         errors++; $display("FAIL wrap_word256: got %h expected 01", cap[255]);
      end
      dups = 0;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      for (int i = 0; i < 255; i++) begin
         if (seen[cap[i]]) dups++;
         seen[cap[i]] = 1'b1;
      end
      checks++;
      if (dups != 0) begin
         errors++; $display("FAIL wrap_repeats: got %0d repeats expected 0", dups);
      end
   endtask

   task automatic test_zero_words();
      run_words(8'h37, 0, 0);
   endtask

   task automatic test_reset_midrun();
      start = 1'b1; seed_in = 8'h00; num_words = 16'd10; sif.out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (sif.out_data !== 8'h01) begin
         errors++; $display("FAIL midrun_w0: got %h expected 01", sif.out_data);
      end
      start = 1'b1; seed_in = 8'h33; num_words = 16'd2;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (sif.out_data !== 8'h02 || seed_fixed !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL midrun_w1: got data=%h fixed=%b busy=%b expected data=02 fixed=1 busy=1",
                            sif.out_data, seed_fixed, busy);
      end
      @(negedge clk);
      checks++;
      if (sif.out_data !== 8'h04) begin
         errors++; $display("FAIL midrun_w2: got %h expected 04", sif.out_data);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({sif.out_valid, busy, done, seed_fixed} !== 4'b0000) begin
         errors++; $display("FAIL midrun_reset_flags: got %b expected 0000", {sif.out_valid, busy, done, seed_fixed});
      end
      checks++;
      if ({node_ld, node_en, node_seed, node_d} !== 32'h0) begin
         errors++; $display("FAIL midrun_reset_nodes: got %h expected 00000000", {node_ld, node_en, node_seed, node_d});
      end
      @(negedge clk);
      checks++;
      if (node_q !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrun_clear: got q=%h done=%b busy=%b expected q=00 done=0 busy=0",
                            node_q, done, busy);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrun_quiet: got done=%b busy=%b expected 0 0", done, busy);
         end
      end
      run_words(8'h5A, 4, 0);
   endtask

   task automatic test_back_to_back();
      run_words(8'h11, 3, 0);
      run_words(8'hC3, 2, 1);
   endtask

   task automatic test_random();
      repeat (6) begin
         run_words(8'($urandom_range(0, 255)), $urandom_range(1, 20), 2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_seed();
      test_wrap();
      test_zero_words();
      test_reset_midrun();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
